sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
N-channel arbiter that merges the core's SRAM-like request ports onto a single downstream SRAM-like port. The typical pairing is the IF instruction port and the EXE/MEM data port, with the single port feeding the AXI bridge. It tracks up to OUTSTANDING in-flight transactions in an in-order tag FIFO, so each data_ok/rdata response goes back to the channel that issued the request. Fixed-priority and round-robin modes are both supported, selected by parameter.

Parameters:
N_CH, 2, number of master channels (2..8); channel 0 is the data port by convention.
OUTSTANDING, 4, tag FIFO depth (power of 2, 2..16); maximum number of accepted requests still awaiting data_ok.
PRIO_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
clk  in  1  system clock.
resetn  in  1  asynchronous active-low reset.
m_req  in  N_CH  per-channel request valid.
m_wr  in  N_CH  per-channel write flag.
m_size  in  2*N_CH  per-channel size (0 = byte, 1 = half, 2 = word).
m_addr  in  32*N_CH  per-channel address.
m_wdata  in  32*N_CH  per-channel write data.
m_addr_ok  out  N_CH  per-channel request accepted.
m_data_ok  out  N_CH  per-channel response valid.
m_rdata  out  32  read data, broadcast to all channels.
s_req  out  1  downstream request valid.
s_wr  out  1  downstream write flag.
s_size  out  2  downstream size.
s_addr  out  32  downstream address.
s_wdata  out  32  downstream write data.
s_addr_ok  in  1  downstream request accepted.
s_data_ok  in  1  downstream response valid.
s_rdata  in  32  downstream read data.
outstanding  out  $clog2(OUTSTANDING+1)  number of in-flight transactions.
err_unexp  out  1  sticky flag: s_data_ok arrived with no transaction in flight.

Behaviour:
- Reset (resetn low, asynchronous): FIFO empty, outstanding = 0, rr_ptr = 0, lock = 0, err_unexp = 0.
- While resetn is low, s_req, all m_addr_ok and all m_data_ok are 0.
- Arbitration, combinational from m_req, the lock state and rr_ptr:
  - PRIO_MODE 0: the lowest-index requester wins.
  - PRIO_MODE 1: the first requester at or after rr_ptr wins, scanning upward with wrap.
- s_req = (any m_req) & ~fifo_full. s_wr, s_size, s_addr and s_wdata are muxed from the granted channel; they are 0 when s_req = 0.
- Grant lock:
  - When s_req = 1 and s_addr_ok = 0, lock <= 1 and locked_ch <= grant.
  - While locked, the grant is forced to locked_ch regardless of other requests, so downstream request fields stay stable.
  - The lock clears on the cycle of the s_addr_ok handshake.
- Handshake:
  - m_addr_ok[g] = s_addr_ok & s_req for the granted channel g; 0 for all others.
  - On a handshake, push g into the FIFO.
  - In PRIO_MODE 1, rr_ptr <= (g+1) mod N_CH on each handshake; rr_ptr does not change on cycles without a handshake.
- Response:
  - On s_data_ok with the FIFO non-empty, m_data_ok[head] = 1 in the same cycle (combinational) and the FIFO pops. m_rdata = s_rdata in all cycles.
  - On s_data_ok with the FIFO empty, no m_data_ok is asserted and err_unexp <= 1. err_unexp clears only on reset.
- Push and pop in the same cycle: both happen, outstanding is unchanged, and read/write pointers each advance with wrap mod OUTSTANDING.
- FIFO full (outstanding == OUTSTANDING): s_req is held 0, so there is no push. A pop in that cycle frees a slot, and s_req may assert on the following cycle.
- A lock held when the FIFO becomes full cannot occur, because a locked request is never withdrawn by the arbiter while not full.
- Responses return strictly in acceptance order. A new request may be accepted in the same cycle as a response.
- Latency: zero added cycles in either direction (purely combinational request and response paths). The only registered elements are the FIFO, counters, lock and flags.

Test Plan:
- Single read on channel 1: addr 0xBFC0_0000, s_addr_ok next cycle, s_data_ok 3 cycles later with rdata 0x1234_5678 -> m_addr_ok[1] pulses once; m_data_ok[1] pulses once with m_rdata = 0x1234_5678; outstanding goes 0→1→0.
- PRIO_MODE 0, both channels requesting continuously, s_addr_ok = 1 -> channel 0 is granted every cycle; channel 1 never gets m_addr_ok.
- PRIO_MODE 1, both channels requesting, s_addr_ok = 1 -> grants alternate 0,1,0,1; rr_ptr wraps correctly with N_CH = 3 (sequence 0,1,2,0).
- Lock: ch1 granted with s_addr_ok held low for 2 cycles while ch0 raises req in cycle 2 -> s_addr stays at ch1's address until the handshake; ch0 is granted afterwards.
- Fill: 4 accepted requests with no data_ok (OUTSTANDING = 4) -> s_req = 0 and outstanding = 4. One s_data_ok pops the head to the correct channel, and s_req reasserts the next cycle.
- Interleaved ch0, ch1, ch0 accepts, then 3 data_ok responses -> m_data_ok goes to ch0, ch1, ch0 in order. A spurious s_data_ok afterwards sets err_unexp = 1. Asserting resetn low mid-traffic clears outstanding and err_unexp immediately.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// N-channel arbiter merging SRAM-like request ports onto one downstream port.
// An in-order tag FIFO steers each data_ok back to the channel that issued it.
module sram_like_arbiter #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned PRIO_MODE   = 0
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [N_CH-1:0]                    m_req,
    input  logic [N_CH-1:0]                    m_wr,
    input  logic [2*N_CH-1:0]                  m_size,
    input  logic [32*N_CH-1:0]                 m_addr,
    input  logic [32*N_CH-1:0]                 m_wdata,
    output logic [N_CH-1:0]                    m_addr_ok,
    output logic [N_CH-1:0]                    m_data_ok,
    output logic [31:0]                        m_rdata,
    output logic                               s_req,
    output logic                               s_wr,
    output logic [1:0]                         s_size,
    output logic [31:0]                        s_addr,
    output logic [31:0]                        s_wdata,
    input  logic                               s_addr_ok,
    input  logic                               s_data_ok,
    input  logic [31:0]                        s_rdata,
    output logic [$clog2(OUTSTANDING+1)-1:0]   outstanding,
    output logic                               err_unexp
);

    localparam int unsigned GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PW = $clog2(OUTSTANDING);
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);

    logic [GW-1:0] r_fifo [OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [GW-1:0] r_rr_ptr;
    logic          r_lock;
    logic [GW-1:0] r_locked_ch;
    logic          r_err;

    logic [GW-1:0] w_grant;
    logic [GW-1:0] w_head;
    logic          w_found;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == CW'(OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rptr];

    // Scan upward from rr_ptr, then wrap; rr_ptr stays 0 in fixed-priority mode.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m_req[i] && (GW'(i) >= r_rr_ptr)) begin
                w_grant = GW'(i);
                w_found = 1'b1;
            end
        end
        if (!w_found) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (m_req[i]) w_grant = GW'(i);
            end
        end
        if (r_lock) w_grant = r_locked_ch;
    end

    assign s_req  = resetn & (|m_req) & ~w_full;
    assign w_push = s_req & s_addr_ok;
    assign w_pop  = resetn & s_data_ok & ~w_empty;

    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s_req && (w_grant == GW'(i))) begin
                s_wr         = m_wr[i];
                s_size       = m_size[2*i +: 2];
                s_addr       = m_addr[32*i +: 32];
                s_wdata      = m_wdata[32*i +: 32];
                m_addr_ok[i] = s_addr_ok;
            end
            if (w_pop && (w_head == GW'(i))) m_data_ok[i] = 1'b1;
        end
    end

    assign m_rdata     = s_rdata;
    assign outstanding = r_count;
    assign err_unexp   = r_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rr_ptr    <= '0;
            r_lock      <= 1'b0;
            r_locked_ch <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (s_data_ok && w_empty) r_err <= 1'b1;
            // Hold the grant while downstream stalls so request fields stay stable.
            if (w_push) begin
                r_lock <= 1'b0;
            end else if (s_req) begin
                r_lock      <= 1'b1;
                r_locked_ch <= w_grant;
            end
            if ((PRIO_MODE == 1) && w_push) begin
                r_rr_ptr <= (w_grant == GW'(N_CH - 1)) ? '0 : w_grant + GW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= w_grant;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: a cycle table on a 2-channel fixed-priority arbiter, plus
// hand sequences for responses/reset and round-robin on a 3-channel instance.
module tb_sram_like_arbiter;

    logic clk;
    logic resetn;

    logic [1:0]  a_req, a_wr, a_aok, a_dok;
    logic [3:0]  a_size;
    logic [63:0] a_addr, a_wdata;
    logic [31:0] a_mrdata, a_saddr, a_swdata, a_srdata;
    logic        a_sreq, a_swr, a_sok, a_sdok, a_err;
    logic [1:0]  a_ssize;
    logic [2:0]  a_out;

    logic [2:0]  b_req, b_wr, b_aok, b_dok;
    logic [5:0]  b_size;
    logic [95:0] b_addr, b_wdata;
    logic [31:0] b_mrdata, b_saddr, b_swdata, b_srdata;
    logic        b_sreq, b_swr, b_sok, b_sdok, b_err;
    logic [1:0]  b_ssize;
    logic [3:0]  b_out;

    int n_chk;
    int n_fail;

    logic [31:0] ch_addr  [2];
    logic [31:0] ch_wdata [2];
    logic        ch_wr    [2];
    logic [1:0]  ch_size  [2];

    sram_like_arbiter #(.N_CH(2), .OUTSTANDING(4), .PRIO_MODE(0)) u_dut_a (
        .clk(clk), .resetn(resetn),
        .m_req(a_req), .m_wr(a_wr), .m_size(a_size), .m_addr(a_addr), .m_wdata(a_wdata),
        .m_addr_ok(a_aok), .m_data_ok(a_dok), .m_rdata(a_mrdata),
        .s_req(a_sreq), .s_wr(a_swr), .s_size(a_ssize), .s_addr(a_saddr), .s_wdata(a_swdata),
        .s_addr_ok(a_sok), .s_data_ok(a_sdok), .s_rdata(a_srdata),
        .outstanding(a_out), .err_unexp(a_err)
    );

    sram_like_arbiter #(.N_CH(3), .OUTSTANDING(8), .PRIO_MODE(1)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .m_req(b_req), .m_wr(b_wr), .m_size(b_size), .m_addr(b_addr), .m_wdata(b_wdata),
        .m_addr_ok(b_aok), .m_data_ok(b_dok), .m_rdata(b_mrdata),
        .s_req(b_sreq), .s_wr(b_swr), .s_size(b_ssize), .s_addr(b_saddr), .s_wdata(b_swdata),
        .s_addr_ok(b_sok), .s_data_ok(b_sdok), .s_rdata(b_srdata),
        .outstanding(b_out), .err_unexp(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0] req;
        logic       sok;
        logic       dok;
        logic       sreq;
        logic       gch;
        logic [1:0] aok;
        logic [1:0] dok_e;
        logic [2:0] out;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    function automatic vec_t v(input int req, input int sok, input int dok, input int sreq,
                               input int gch, input int aok, input int dk, input int out);
        vec_t r;
        r.req   = 2'(req);
        r.sok   = 1'(sok);
        r.dok   = 1'(dok);
        r.sreq  = 1'(sreq);
        r.gch   = 1'(gch);
        r.aok   = 2'(aok);
        r.dok_e = 2'(dk);
        r.out   = 3'(out);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        ch_addr[0]  = 32'h0000_1000;  ch_addr[1]  = 32'hBFC0_0000;
        ch_wdata[0] = 32'hDEAD_0000;  ch_wdata[1] = 32'hBEEF_1111;
        ch_wr[0]    = 1'b1;           ch_wr[1]    = 1'b0;
        ch_size[0]  = 2'd2;           ch_size[1]  = 2'd1;
        a_addr  = {ch_addr[1], ch_addr[0]};
        a_wdata = {ch_wdata[1], ch_wdata[0]};
        a_wr    = {ch_wr[1], ch_wr[0]};
        a_size  = {ch_size[1], ch_size[0]};
        a_req = '0; a_sok = 1'b0; a_sdok = 1'b0; a_srdata = '0;
        b_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        b_wdata = '0; b_wr = '0; b_size = '0;
        b_req = '0; b_sok = 1'b0; b_sdok = 1'b0; b_srdata = '0;

        //          req  sok dok sreq gch aok  dok  out
        vecs[0]  = v(2'b10, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        vecs[1]  = v(2'b10, 1, 0, 1, 1, 2'b10, 2'b00, 0);
        vecs[2]  = v(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        vecs[3]  = v(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1);
        vecs[4]  = v(2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 1);
        vecs[5]  = v(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        vecs[6]  = v(2'b11, 1, 0, 1, 0, 2'b01, 2'b00, 0);
        vecs[7]  = v(2'b11, 1, 0, 1, 0, 2'b01, 2'b00, 1);
        vecs[8]  = v(2'b11, 1, 1, 1, 0, 2'b01, 2'b01, 2);
        vecs[9]  = v(2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 2);
        vecs[10] = v(2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 1);
        vecs[11] = v(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        vecs[12] = v(2'b10, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        vecs[13] = v(2'b11, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        vecs[14] = v(2'b11, 1, 0, 1, 1, 2'b10, 2'b00, 0);
        vecs[15] = v(2'b01, 1, 0, 1, 0, 2'b01, 2'b00, 1);
        vecs[16] = v(2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 2);
        vecs[17] = v(2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 1);
        vecs[18] = v(2'b01, 1, 0, 1, 0, 2'b01, 2'b00, 0);
        vecs[19] = v(2'b10, 1, 0, 1, 1, 2'b10, 2'b00, 1);
        vecs[20] = v(2'b01, 1, 0, 1, 0, 2'b01, 2'b00, 2);
        vecs[21] = v(2'b10, 1, 0, 1, 1, 2'b10, 2'b00, 3);
        vecs[22] = v(2'b11, 1, 0, 0, 0, 2'b00, 2'b00, 4);
        vecs[23] = v(2'b11, 1, 1, 0, 0, 2'b00, 2'b01, 4);
        vecs[24] = v(2'b11, 0, 0, 1, 0, 2'b00, 2'b00, 3);
        vecs[25] = v(2'b11, 1, 0, 1, 0, 2'b01, 2'b00, 3);
        vecs[26] = v(2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 4);
        vecs[27] = v(2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 3);
        vecs[28] = v(2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 2);
        vecs[29] = v(2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 1);
        vecs[30] = v(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0);

        // Outputs must stay quiet in reset even with requests and responses present.
        resetn = 1'b0;
        a_req  = 2'b11; a_sok = 1'b1; a_sdok = 1'b1;
        #7;
        chk("rst_s_req", 32'(a_sreq), 32'd0);
        chk("rst_addr_ok", 32'(a_aok), 32'd0);
        chk("rst_data_ok", 32'(a_dok), 32'd0);
        chk("rst_outstanding", 32'(a_out), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        a_req = '0; a_sok = 1'b0; a_sdok = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            a_req    = vecs[i].req;
            a_sok    = vecs[i].sok;
            a_sdok   = vecs[i].dok;
            a_srdata = 32'h1234_5600 + 32'(i);
            #1;
            chk($sformatf("v%0d_s_req", i), 32'(a_sreq), 32'(vecs[i].sreq));
            chk($sformatf("v%0d_s_addr", i), a_saddr,
                vecs[i].sreq ? ch_addr[vecs[i].gch] : 32'h0);
            chk($sformatf("v%0d_s_wdata", i), a_swdata,
                vecs[i].sreq ? ch_wdata[vecs[i].gch] : 32'h0);
            chk($sformatf("v%0d_s_wr", i), 32'(a_swr),
                vecs[i].sreq ? 32'(ch_wr[vecs[i].gch]) : 32'h0);
            chk($sformatf("v%0d_s_size", i), 32'(a_ssize),
                vecs[i].sreq ? 32'(ch_size[vecs[i].gch]) : 32'h0);
            chk($sformatf("v%0d_addr_ok", i), 32'(a_aok), 32'(vecs[i].aok));
            chk($sformatf("v%0d_data_ok", i), 32'(a_dok), 32'(vecs[i].dok_e));
            chk($sformatf("v%0d_outstanding", i), 32'(a_out), 32'(vecs[i].out));
            chk($sformatf("v%0d_m_rdata", i), a_mrdata, 32'h1234_5600 + 32'(i));
            cycle();
        end
        a_req = '0; a_sok = 1'b0; a_sdok = 1'b0;

        // Interleaved ch0, ch1, ch0 accepts, then in-order responses.
        a_sok = 1'b1;
        a_req = 2'b01; #1; chk("il_acc0", 32'(a_aok), 32'b01); cycle();
        a_req = 2'b10; #1; chk("il_acc1", 32'(a_aok), 32'b10); cycle();
        a_req = 2'b01; #1; chk("il_acc2", 32'(a_aok), 32'b01); cycle();
        a_req = 2'b00; a_sok = 1'b0;
        #1; chk("il_out3", 32'(a_out), 32'd3);
        a_sdok = 1'b1;
        a_srdata = 32'hA000_0000; #1;
        chk("il_rsp0", 32'(a_dok), 32'b01); chk("il_rd0", a_mrdata, 32'hA000_0000); cycle();
        a_srdata = 32'hA000_0001; #1;
        chk("il_rsp1", 32'(a_dok), 32'b10); chk("il_rd1", a_mrdata, 32'hA000_0001); cycle();
        a_srdata = 32'hA000_0002; #1;
        chk("il_rsp2", 32'(a_dok), 32'b01); chk("il_rd2", a_mrdata, 32'hA000_0002); cycle();
        // Spurious response with nothing in flight.
        #1; chk("sp_no_dok", 32'(a_dok), 32'b00); chk("sp_err_pre", 32'(a_err), 32'd0);
        cycle();
        a_sdok = 1'b0;
        #1; chk("sp_err_set", 32'(a_err), 32'd1); cycle();
        #1; chk("sp_err_sticky", 32'(a_err), 32'd1);
        // Asynchronous reset in the middle of traffic.
        a_req = 2'b01; a_sok = 1'b1; cycle();
        a_req = 2'b11; a_sok = 1'b0;
        #1; chk("mr_out_pre", 32'(a_out), 32'd1); chk("mr_sreq_pre", 32'(a_sreq), 32'd1);
        resetn = 1'b0; a_sdok = 1'b1;
        #1;
        chk("mr_out", 32'(a_out), 32'd0);
        chk("mr_err", 32'(a_err), 32'd0);
        chk("mr_sreq", 32'(a_sreq), 32'd0);
        chk("mr_dok", 32'(a_dok), 32'd0);
        a_req = '0; a_sdok = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Round-robin on 3 channels: two requesters alternate.
        do_reset();
        b_sok = 1'b1;
        b_req = 3'b011;
        #1; chk("rr2_g0", 32'(b_aok), 32'b001); cycle();
        #1; chk("rr2_g1", 32'(b_aok), 32'b010); cycle();
        #1; chk("rr2_g2", 32'(b_aok), 32'b001); cycle();
        #1; chk("rr2_g3", 32'(b_aok), 32'b010); cycle();
        b_req = '0; b_sok = 1'b0;
        #1; chk("rr2_out", 32'(b_out), 32'd4);
        b_sdok = 1'b1;
        #1; chk("rr2_r0", 32'(b_dok), 32'b001); cycle();
        #1; chk("rr2_r1", 32'(b_dok), 32'b010); cycle();
        #1; chk("rr2_r2", 32'(b_dok), 32'b001); cycle();
        #1; chk("rr2_r3", 32'(b_dok), 32'b010); cycle();
        b_sdok = 1'b0;
        #1; chk("rr2_err", 32'(b_err), 32'd0);

        // Three requesters: 0,1,2 then wrap to 0.
        do_reset();
        b_sok = 1'b1;
        b_req = 3'b111;
        #1; chk("rr3_g0", 32'(b_aok), 32'b001); chk("rr3_a0", b_saddr, 32'h100); cycle();
        #1; chk("rr3_g1", 32'(b_aok), 32'b010); chk("rr3_a1", b_saddr, 32'h200); cycle();
        #1; chk("rr3_g2", 32'(b_aok), 32'b100); chk("rr3_a2", b_saddr, 32'h300); cycle();
        #1; chk("rr3_g3", 32'(b_aok), 32'b001); chk("rr3_a3", b_saddr, 32'h100); cycle();
        b_req = '0; b_sok = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
